// File: rtl/ysyx_22040750_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040750_if_stage
// Desc     : Instruction-fetch stage. Owns the fetch PC, keeps one imem read
//            outstanding at a time and presents {pc, inst} to IF/ID.
//            Optional macro IF_MISALIGN_CHECK_EN adds a sticky O_fetch_misalign
//            flag and loads redirect targets unmodified.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040750_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_imem_req,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_ack,
  input  logic        I_imem_rvalid,
  input  logic [31:0] I_imem_rdata,
  input  logic        I_IF_ID_allowin,
  output logic        O_IF_ID_valid,
  output logic [31:0] O_pc,
  output logic [31:0] O_inst
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        O_fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [31:0] C_PC_STEP    = 32'd4;
  localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_discard;
  logic        r_imem_req;
  logic        r_if_id_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] w_redirect_target;

`ifdef IF_MISALIGN_CHECK_EN
  logic r_fetch_misalign;

  assign w_redirect_target = I_redirect_pc;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_fetch_misalign <= 1'b0;
    end else if (I_redirect && (I_redirect_pc[1:0] != 2'b00)) begin
      r_fetch_misalign <= 1'b1;
    end
  end

  assign O_fetch_misalign = r_fetch_misalign;
`else
  assign w_redirect_target = I_redirect_pc & C_ALIGN_MASK;
`endif

  // Redirect always wins over the sequential +4 step; a response already in
  // flight when the redirect lands is marked for discard.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_discard     <= 1'b0;
      r_imem_req    <= 1'b1;
      r_if_id_valid <= 1'b0;
      r_pc          <= 32'd0;
      r_inst        <= 32'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (I_redirect) begin
            r_fetch_pc <= w_redirect_target;
          end
          if (I_imem_ack) begin
            r_state    <= S_WAIT;
            r_discard  <= I_redirect;
            r_imem_req <= 1'b0;
          end
        end

        S_WAIT: begin
          if (I_redirect) begin
            r_fetch_pc <= w_redirect_target;
          end
          if (I_imem_rvalid) begin
            if (r_discard || I_redirect) begin
              r_state    <= S_REQ;
              r_discard  <= 1'b0;
              r_imem_req <= 1'b1;
            end else begin
              r_state       <= S_VALID;
              r_pc          <= r_fetch_pc;
              r_inst        <= I_imem_rdata;
              r_if_id_valid <= 1'b1;
            end
          end else if (I_redirect) begin
            r_discard <= 1'b1;
          end
        end

        S_VALID: begin
          if (I_redirect || I_IF_ID_allowin) begin
            r_fetch_pc    <= I_redirect ? w_redirect_target : (r_fetch_pc + C_PC_STEP);
            r_state       <= S_REQ;
            r_imem_req    <= 1'b1;
            r_if_id_valid <= 1'b0;
          end
        end

        default: begin
          r_state       <= S_REQ;
          r_discard     <= 1'b0;
          r_imem_req    <= 1'b1;
          r_if_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign O_imem_req    = r_imem_req;
  assign O_imem_addr   = r_fetch_pc;
  assign O_IF_ID_valid = r_if_id_valid;
  assign O_pc          = r_pc;
  assign O_inst        = r_inst;

endmodule

`default_nettype wire
